// File: rtl/feature_pkg.sv
// Shared definitions for the feature-map BRAM read path.
//   DEF_ADDR_W / DEF_DATA_W / DEF_DIM_W : default widths for reader instances
//   RD_LATENCY : registered read latency of feature_bram (clocks)
//   FIFO_DEPTH : output skid FIFO depth; also the read credit limit
//   COUNT_W    : width of a 0..FIFO_DEPTH occupancy count
//   state_t    : reader FSM states
package feature_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIM_W  = 12;
  localparam int RD_LATENCY = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int COUNT_W    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO used as the reader's output buffer.
// Ports:
//   clk, reset   : clock, synchronous active-low reset (flushes pointers/count)
//   push, din    : write request and word
//   pop          : read request (head advances); ignored when empty
//   dout         : head word, meaningful only while !empty
//   full, empty  : occupancy flags
//   count        : current occupancy, 0..FIFO_DEPTH
module stream_fifo
  import feature_pkg::*;
#(
  parameter int W = DEF_DATA_W + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [W-1:0]       din,
  input  logic               pop,
  output logic [W-1:0]       dout,
  output logic               full,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == COUNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + COUNT_W'(do_push) - COUNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; pointers/count define validity
  // and the consumer masks the head while empty, so no reset fan-out is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/feature_bram_reader.sv
// Raster-order region reader for feature_bram.
// Walks width x height pixels starting at base_addr (rows row_pitch apart),
// drives the BRAM read address, absorbs the 1-clk read latency and emits the
// pixels on a valid/ready stream at up to 1 pixel/clk.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   start                 : command strobe, sampled only while idle
//   base_addr, width,
//   height, row_pitch     : region description, latched on start
//   rd_addr / rd_data     : BRAM read port (data valid 1 clk after address)
//   m_data, m_valid,
//   m_ready, m_row_last,
//   m_last                : output pixel stream with row/region end tags
//   busy                  : region in progress
//   done                  : 1-clk pulse after the final beat (or on an empty region)
module feature_bram_reader
  import feature_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [ADDR_W-1:0] row_pitch,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_row_last,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  state_t state_q, state_d;

  logic [DIM_W-1:0]  w_q, h_q, col_q, row_q;
  logic [ADDR_W-1:0] pitch_q, row_start_q, rd_addr_q;

  // In-flight pipe: stage 0 tracks the address on rd_addr, stage 1 the word
  // the BRAM is presenting on rd_data.
  logic p0_valid_q, p0_row_last_q, p0_last_q;
  logic p1_valid_q, p1_row_last_q, p1_last_q;
  logic done_q;

  logic               accept, reject, issue_run, credit_ok;
  logic               col_wrap, run_row_last, run_last, acc_row_last, acc_last;
  logic [DIM_W-1:0]   nxt_col, nxt_row;
  logic [ADDR_W-1:0]  nxt_addr, nxt_row_start;
  logic               beat, final_beat;

  logic [DATA_W+1:0]  fifo_din, fifo_dout;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [COUNT_W-1:0] fifo_count;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned (which would infer a latch).
  always_comb begin
    accept        = 1'b0;
    reject        = 1'b0;
    issue_run     = 1'b0;
    state_d       = state_q;

    // Credit: buffered words plus reads still in the pipe never exceed the
    // FIFO depth, so every issued read has a slot waiting for it.
    credit_ok = (fifo_count + COUNT_W'(p0_valid_q) + COUNT_W'(p1_valid_q))
                < COUNT_W'(FIFO_DEPTH);

    col_wrap      = (col_q == w_q - DIM_W'(1));
    nxt_col       = col_wrap ? '0 : col_q + DIM_W'(1);
    nxt_row       = col_wrap ? row_q + DIM_W'(1) : row_q;
    nxt_row_start = col_wrap ? row_start_q + pitch_q : row_start_q;
    nxt_addr      = col_wrap ? row_start_q + pitch_q : rd_addr_q + ADDR_W'(1);
    run_row_last  = (nxt_col == w_q - DIM_W'(1));
    run_last      = run_row_last && (nxt_row == h_q - DIM_W'(1));

    acc_row_last  = (width == DIM_W'(1));
    acc_last      = acc_row_last && (height == DIM_W'(1));

    beat          = m_valid && m_ready;
    final_beat    = beat && m_last;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (width == '0 || height == '0) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = acc_last ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        issue_run = credit_ok;
        if (credit_ok && run_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The tagged last beat is also the last word pushed, so its transfer
        // implies the FIFO and the pipe are empty.
        if (final_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_q           <= '0;
      h_q           <= '0;
      col_q         <= '0;
      row_q         <= '0;
      pitch_q       <= '0;
      row_start_q   <= '0;
      rd_addr_q     <= '0;
      p0_valid_q    <= 1'b0;
      p0_row_last_q <= 1'b0;
      p0_last_q     <= 1'b0;
      p1_valid_q    <= 1'b0;
      p1_row_last_q <= 1'b0;
      p1_last_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      p1_valid_q    <= p0_valid_q;
      p1_row_last_q <= p0_row_last_q;
      p1_last_q     <= p0_last_q;
      p0_valid_q    <= accept || issue_run;
      p0_row_last_q <= accept ? acc_row_last : run_row_last;
      p0_last_q     <= accept ? acc_last : run_last;
      done_q        <= reject || (state_q == ST_DRAIN && final_beat);

      if (accept) begin
        w_q         <= width;
        h_q         <= height;
        pitch_q     <= row_pitch;
        col_q       <= '0;
        row_q       <= '0;
        row_start_q <= base_addr;
        rd_addr_q   <= base_addr;
      end else if (issue_run) begin
        col_q       <= nxt_col;
        row_q       <= nxt_row;
        row_start_q <= nxt_row_start;
        rd_addr_q   <= nxt_addr;
      end
    end
  end

  assign fifo_din  = {p1_row_last_q, p1_last_q, rd_data};
  assign fifo_push = p1_valid_q;
  assign fifo_pop  = beat;

  stream_fifo #(.W(DATA_W + 2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head fields are masked while empty so the stream outputs read 0 after
  // reset even though the FIFO storage itself is not cleared.
  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign m_row_last = !fifo_empty && fifo_dout[DATA_W+1];
  assign m_last     = !fifo_empty && fifo_dout[DATA_W];

  assign rd_addr = rd_addr_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_feature_bram_reader.sv
// Self-checking bench for feature_bram_reader: a BRAM model (mem[i]=i*7+1)
// feeds the reader; each accepted region pushes its expected beats into a
// scoreboard queue and an independent monitor compares every transferred beat.
module tb_feature_bram_reader;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int DMW = 12;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          row_last;
    logic          last;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [DMW-1:0] width;
  logic [DMW-1:0] height;
  logic [AW-1:0]  row_pitch;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_ready;
  logic           m_row_last;
  logic           m_last;
  logic           busy;
  logic           done;

  feature_bram_reader #(.ADDR_W(AW), .DATA_W(DW), .DIM_W(DMW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .width      (width),
    .height     (height),
    .row_pitch  (row_pitch),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_row_last (m_row_last),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // BRAM model: one-clock registered read.
  logic [DW-1:0] mem [1 << AW];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 7 + 1);
  always @(posedge clk) rd_data <= mem[rd_addr];

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    beat_cyc[$];
  int    last_beat_cyc = -1;
  int    beats_seen = 0;
  int    start_cyc = 0;
  int    done_cyc = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the region in raster order, addresses modulo 2^AW.
  task automatic model_frame(input int base, input int w, input int h, input int pitch);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int    a;
        beat_t b;
        a          = (base + r * pitch + c) % (1 << AW);
        b.data     = mem[a];
        b.row_last = (c == w - 1);
        b.last     = (c == w - 1) && (r == h - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Monitor: samples on the falling edge, i.e. what the next rising edge transfers.
  beat_t          got_e;
  logic           prev_ok = 1'b0;
  logic           prev_valid = 1'b0;
  logic           prev_ready = 1'b0;
  logic [DW+1:0]  prev_head = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_data, m_row_last, m_last}, 32'hFFFF_FFFF);
        end else begin
          got_e = exp_q.pop_front();
          check("beat", {m_data, m_row_last, m_last}, got_e);
        end
        beat_cyc.push_back(cyc);
        beats_seen++;
        if (m_last) last_beat_cyc = cyc;
      end
      if (prev_ok && prev_valid && !prev_ready)
        check("stall_hold", {m_valid, m_data, m_row_last, m_last}, {1'b1, prev_head});
    end
    prev_ok    = reset;
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_head  = {m_data, m_row_last, m_last};
  end

  // Ready driver: constant 1 or ~50% random, updated just after each rising edge.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_start(input int base, input int w, input int h, input int pitch);
    base_addr = AW'(base);
    width     = DMW'(w);
    height    = DMW'(h);
    row_pitch = AW'(pitch);
    start     = 1'b1;
    beat_cyc.delete();
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  // Returns at the falling edge where done is seen high.
  task automatic wait_done(input string name, input int limit);
    int n    = 0;
    bit seen = 1'b0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 1);
    check({name, "_busy_at_done"}, 32'(busy), 0);
    check({name, "_all_beats"}, exp_q.size(), 0);
    done_cyc = cyc;
  endtask

  // Addresses presented on consecutive clocks (full throughput, m_ready=1).
  task automatic check_addr_seq(input string name, input int base, input int w, input int h, input int pitch);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        check(name, 32'(rd_addr), (base + r * pitch + c) % (1 << AW));
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {rd_addr, m_data, m_valid, m_row_last, m_last, busy, done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0;
    base_addr = '0; width = '0; height = '0; row_pitch = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_values");
    reset = 1'b1;
    @(posedge clk); #1;

    // Dense region, full throughput.
    model_frame(0, 4, 2, 4);
    do_start(0, 4, 2, 4);
    check("dense_busy", 32'(busy), 1);
    check("dense_first_addr", 32'(rd_addr), 0);
    wait_done("dense", 100);
    check("dense_beat_count", beat_cyc.size(), 8);
    if (beat_cyc.size() == 8) begin
      check("dense_latency", beat_cyc[0], start_cyc + 2);
      check("dense_back_to_back", beat_cyc[7] - beat_cyc[0], 7);
    end
    check("dense_done_timing", done_cyc, last_beat_cyc + 1);

    // Strided region, started in the cycle done is high.
    model_frame(16, 3, 2, 8);
    do_start(16, 3, 2, 8);
    check_addr_seq("strided_addr", 16, 3, 2, 8);
    wait_done("strided", 100);

    // Address wrap.
    model_frame(4094, 4, 1, 0);
    do_start(4094, 4, 1, 0);
    check_addr_seq("wrap_addr", 4094, 4, 1, 0);
    wait_done("wrap", 100);
    @(posedge clk); #1;

    // Degenerate regions: done pulse, no beats, never busy.
    for (int k = 0; k < 2; k++) begin
      logic any_valid;
      do_start(5, (k == 0) ? 0 : 3, (k == 0) ? 3 : 0, 1);
      check("degen_done", 32'(done), 1);
      check("degen_busy", 32'(busy), 0);
      any_valid = 1'b0;
      @(posedge clk); #1;
      check("degen_done_pulse", 32'(done), 0);
      repeat (5) begin
        @(negedge clk);
        any_valid |= m_valid;
      end
      check("degen_no_valid", 32'(any_valid), 0);
    end

    // Start while busy is ignored.
    model_frame(0, 4, 2, 4);
    do_start(0, 4, 2, 4);
    repeat (2) @(posedge clk);
    #1;
    base_addr = AW'(100); width = DMW'(1); height = DMW'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore_start", 100);
    check("ignore_start_beats", beat_cyc.size(), 8);
    repeat (4) @(negedge clk);
    check("ignore_start_idle", {busy, m_valid}, 0);

    // Backpressure on the dense region, then random regions.
    rand_ready = 1'b1;
    model_frame(0, 4, 2, 4);
    do_start(0, 4, 2, 4);
    wait_done("bp_dense", 400);
    check("bp_dense_beats", beat_cyc.size(), 8);
    for (int k = 0; k < 6; k++) begin
      int b, w, h, p;
      b = $urandom_range(0, (1 << AW) - 1);
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      p = $urandom_range(0, (1 << AW) - 1);
      model_frame(b, w, h, p);
      do_start(b, w, h, p);
      wait_done("random", 600);
      check("random_beats", beat_cyc.size(), w * h);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // Reset while beat 3 of the dense region is presented.
    begin
      int n0, n;
      n0 = beats_seen;
      n  = 0;
      model_frame(0, 4, 2, 4);
      do_start(0, 4, 2, 4);
      while (beats_seen < n0 + 2 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("midreset_reached_beat3", 32'(beats_seen - n0), 2);
      reset = 1'b0;
      @(posedge clk); #1;
      check_outputs_zero("midreset_outputs");
      exp_q.delete();
      reset = 1'b1;
      @(posedge clk); #1;
      model_frame(0, 4, 2, 4);
      do_start(0, 4, 2, 4);
      wait_done("after_reset", 100);
      check("after_reset_beats", beat_cyc.size(), 8);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
